branch_resolve_stage: RTL and testbench

Execute-to-memory boundary stage that sits directly downstream of the 32-bit integer ALU. It consumes the ALU result and the Eq/Gt/GtU comparison flags, resolves conditional branches, and issues a one-cycle fetch redirect for taken branches. It holds results in a two-entry skid buffer with valid/ready handshakes on both sides, so a downstream stall never creates a combinational ready path back into execute.

---
 rtl/branch_resolve_stage.sv | 126 ++++++++++++
 tb/tb_branch_resolve_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_stage.sv
// Execute-to-memory stage: resolves conditional branches, pulses a fetch
// redirect on taken ones, and buffers results in a two-entry skid buffer.
module branch_resolve_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] alu_out,
    input  logic        eq,
    input  logic        gt,
    input  logic        gtu,
    input  logic        is_branch,
    input  logic [2:0]  br_funct3,
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    input  logic [4:0]  rd,
    input  logic        reg_write,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_alu,
    output logic [4:0]  out_rd,
    output logic        out_reg_write,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    typedef struct packed {
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        rw;
    } entry_t;

    state_t      state;
    entry_t      head;
    entry_t      skid;
    entry_t      incoming;
    logic        accept;
    logic        pop;
    logic        cond;
    logic        fire;
    logic [31:0] target;

    assign accept   = in_valid & in_ready;
    assign pop      = out_valid & out_ready;
    assign incoming = {alu_out, rd, reg_write & ~is_branch};
    assign target   = pc + imm;
    assign fire     = accept & is_branch & cond & ~flush;

    assign out_alu       = head.alu;
    assign out_rd        = head.rd;
    assign out_reg_write = head.rw;

    // lt/ltu are derived as !(gt|eq) since the ALU only exports gt flags
    always_comb begin
        cond = 1'b0;
        unique case (br_funct3)
            3'b000:  cond = eq;
            3'b001:  cond = ~eq;
            3'b100:  cond = ~(gt | eq);
            3'b101:  cond = gt | eq;
            3'b110:  cond = ~(gtu | eq);
            3'b111:  cond = gtu | eq;
            default: cond = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= EMPTY;
            head           <= '0;
            skid           <= '0;
            in_ready       <= 1'b1;
            out_valid      <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= fire;
            if (fire)
                redirect_pc <= target;

            if (flush) begin
                state     <= EMPTY;
                out_valid <= 1'b0;
                in_ready  <= 1'b1;
            end else begin
                unique case (state)
                    EMPTY: begin
                        if (accept) begin
                            head      <= incoming;
                            state     <= ONE;
                            out_valid <= 1'b1;
                        end
                    end
                    ONE: begin
                        if (accept && !pop) begin
                            skid     <= incoming;
                            state    <= TWO;
                            in_ready <= 1'b0;
                        end else if (!accept && pop) begin
                            state     <= EMPTY;
                            out_valid <= 1'b0;
                        end else if (accept) begin
                            head <= incoming;
                        end
                    end
                    TWO: begin
                        if (pop) begin
                            head     <= skid;
                            state    <= ONE;
                            in_ready <= 1'b1;
                        end
                    end
                    default: begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_stage.sv
// Directed bench for branch_resolve_stage: decode, wrap, skid
// backpressure, flush, throughput and asynchronous reset.
module tb_branch_resolve_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_out;
    logic        eq;
    logic        gt;
    logic        gtu;
    logic        is_branch;
    logic [2:0]  br_funct3;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        reg_write;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_alu;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    branch_resolve_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_out(alu_out), .eq(eq), .gt(gt), .gtu(gtu),
        .is_branch(is_branch), .br_funct3(br_funct3),
        .pc(pc), .imm(imm), .rd(rd), .reg_write(reg_write),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_alu(out_alu), .out_rd(out_rd),
        .out_reg_write(out_reg_write),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        alu_out   = '0;
        eq        = 1'b0;
        gt        = 1'b0;
        gtu       = 1'b0;
        is_branch = 1'b0;
        br_funct3 = 3'b010;
        pc        = '0;
        imm       = '0;
        rd        = '0;
        reg_write = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] a, input logic [4:0] r,
                       input logic w);
        idle();
        in_valid  = 1'b1;
        alu_out   = a;
        rd        = r;
        reg_write = w;
    endtask

    task automatic put_br(input logic [2:0] f3, input logic e,
                          input logic g, input logic gu,
                          input logic [31:0] p, input logic [31:0] i);
        put(32'h0000_00aa, 5'd5, 1'b1);
        is_branch = 1'b1;
        br_funct3 = f3;
        eq        = e;
        gt        = g;
        gtu       = gu;
        pc        = p;
        imm       = i;
    endtask

    task automatic br_case(input string tag, input logic [2:0] f3,
                           input logic e, input logic g, input logic gu,
                           input logic [31:0] p, input logic [31:0] i,
                           input logic taken, input logic [31:0] tgt);
        out_ready = 1'b1;
        put_br(f3, e, g, gu, p, i);
        tick();
        chk({tag, ".rv"}, 32'(redirect_valid), 32'(taken));
        if (taken)
            chk({tag, ".pc"}, redirect_pc, tgt);
        chk({tag, ".rw"}, 32'(out_reg_write), 32'd0);
        idle();
        tick();
        chk({tag, ".pulse"}, 32'(redirect_valid), 32'd0);
    endtask

    logic [31:0] got[$];
    logic        acc;

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.out_alu", out_alu, 32'd0);
        chk("rst.out_rd", 32'(out_rd), 32'd0);
        chk("rst.out_rw", 32'(out_reg_write), 32'd0);
        chk("rst.rv", 32'(redirect_valid), 32'd0);
        chk("rst.rpc", redirect_pc, 32'd0);
        rst = 1'b0;
        tick();

        br_case("beq", 3'b000, 1, 0, 0, 32'h100, 32'h20, 1, 32'h120);
        chk("beq.hold", redirect_pc, 32'h120);
        br_case("bne", 3'b001, 1, 0, 0, 32'h200, 32'h8, 0, 32'h0);
        br_case("bltu", 3'b110, 0, 1, 0, 32'h300, 32'h40, 1, 32'h340);
        br_case("bge", 3'b101, 1, 0, 0, 32'h400, 32'hffff_fffc, 1,
                32'h3fc);
        br_case("f010", 3'b010, 1, 1, 1, 32'h500, 32'h10, 0, 32'h0);
        br_case("blt", 3'b100, 0, 1, 1, 32'h600, 32'h10, 0, 32'h0);
        br_case("wrap", 3'b000, 1, 0, 0, 32'hffff_fff0, 32'h20, 1,
                32'h10);

        // backpressure: three offers, only two fit
        out_ready = 1'b0;
        put(32'd1, 5'd1, 1'b1);
        tick();
        chk("bp.ready1", 32'(in_ready), 32'd1);
        chk("bp.head1", out_alu, 32'd1);
        put(32'd2, 5'd2, 1'b1);
        tick();
        chk("bp.ready2", 32'(in_ready), 32'd0);
        chk("bp.valid2", 32'(out_valid), 32'd1);
        put(32'd3, 5'd3, 1'b1);
        tick();
        chk("bp.ready3", 32'(in_ready), 32'd0);
        chk("bp.head3", out_alu, 32'd1);
        tick();
        chk("bp.stable", out_alu, 32'd1);
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (out_valid)
                got.push_back(out_alu);
            acc = in_valid & in_ready;
            tick();
            if (acc)
                in_valid = 1'b0;
        end
        chk("bp.count", got.size(), 32'd3);
        for (int k = 0; k < 3 && k < got.size(); k++)
            chk("bp.order", got[k], 32'(k + 1));

        // flush in TWO with a taken branch offered
        out_ready = 1'b0;
        put(32'd7, 5'd7, 1'b1);
        tick();
        put(32'd8, 5'd8, 1'b1);
        tick();
        put_br(3'b000, 1, 0, 0, 32'h100, 32'h20);
        flush = 1'b1;
        tick();
        chk("fl2.valid", 32'(out_valid), 32'd0);
        chk("fl2.ready", 32'(in_ready), 32'd1);
        chk("fl2.rv", 32'(redirect_valid), 32'd0);
        // flush in ONE while a taken branch is really accepted
        put(32'd9, 5'd9, 1'b1);
        tick();
        put_br(3'b001, 0, 0, 0, 32'h800, 32'h4);
        flush = 1'b1;
        tick();
        chk("fl1.valid", 32'(out_valid), 32'd0);
        chk("fl1.rv", 32'(redirect_valid), 32'd0);
        chk("fl1.rpc", redirect_pc, 32'h10);
        idle();
        tick();

        // throughput: one entry per cycle
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            put(32'h1000 + 32'(i), 5'(i), i[0]);
            tick();
            chk("tp.valid", 32'(out_valid), 32'd1);
            chk("tp.alu", out_alu, 32'h1000 + 32'(i));
            chk("tp.rd", 32'(out_rd), 32'(i));
            chk("tp.rw", 32'(out_reg_write), 32'(i[0]));
            chk("tp.ready", 32'(in_ready), 32'd1);
        end
        idle();
        tick();
        chk("tp.drain", 32'(out_valid), 32'd0);

        // async reset while in TWO with a redirect pending
        out_ready = 1'b0;
        put(32'd11, 5'd11, 1'b1);
        tick();
        put_br(3'b000, 1, 0, 0, 32'h40, 32'h40);
        tick();
        idle();
        chk("ar.pre_rv", 32'(redirect_valid), 32'd1);
        chk("ar.pre_ready", 32'(in_ready), 32'd0);
        #1;
        rst = 1'b1;
        #1;
        chk("ar.valid", 32'(out_valid), 32'd0);
        chk("ar.ready", 32'(in_ready), 32'd1);
        chk("ar.rv", 32'(redirect_valid), 32'd0);
        chk("ar.rpc", redirect_pc, 32'd0);
        #1;
        rst = 1'b0;
        tick();
        chk("ar.after", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
